// File: rtl/fullsubtractor_using_halfsubtractor.sv
// -----------------------------------------------------------------------------
// fullsubtractor_using_halfsubtractor
//
// Purpose:
//   Registered WIDTH-bit ripple-borrow subtractor. It computes
//   d = (a - b - bin) mod 2^WIDTH and bout = borrow out of the MSB.
//   Each bit is a full-subtractor cell made of two half_subtractor instances.
//   The combinational result is captured into output registers on every
//   rising clk edge, so latency is one cycle and throughput is one per cycle.
//
// Ports:
//   d     output [WIDTH-1:0]  registered difference
//   bout  output              registered borrow-out
//   a     input  [WIDTH-1:0]  minuend
//   b     input  [WIDTH-1:0]  subtrahend
//   bin   input               borrow-in (borrow into bit 0)
//   clk   input               single clock, rising edge
//   rst   input               synchronous, active-high reset
//                             (clears d and bout, and wins over capture)
//
// Port order is kept as d, bout, a, b, bin, clk, rst. Positional
// hookups of the first five ports therefore keep their meaning.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// half_subtractor
//
// Purpose:
//   One-bit half subtractor computing x - y.
//
// Ports:
//   x     input   minuend bit
//   y     input   subtrahend bit
//   diff  output  x XOR y
//   brw   output  borrow, (NOT x) AND y
// -----------------------------------------------------------------------------
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic brw
);

  assign diff = x ^ y;
  assign brw  = ~x & y;

endmodule : half_subtractor

module fullsubtractor_using_halfsubtractor #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] d,
  output logic             bout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             clk,
  input  logic             rst
);

  // borrow_s[i] is the borrow into bit i. borrow_s[WIDTH] is the borrow out of the MSB.
  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] diff_s;

  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;
  logic             bout_d;
  logic             bout_q;

  assign borrow_s[0] = bin;

  // Ripple chain: each cell is HS1(a,b) followed by HS2(d1, borrow_in).
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic d1_s;
    logic b1_s;
    logic b2_s;

    half_subtractor u_hs1 (
      .x    (a[i]),
      .y    (b[i]),
      .diff (d1_s),
      .brw  (b1_s)
    );

    half_subtractor u_hs2 (
      .x    (d1_s),
      .y    (borrow_s[i]),
      .diff (diff_s[i]),
      .brw  (b2_s)
    );

    // At most one of b1/b2 can be set, so OR gives the cell borrow-out.
    assign borrow_s[i+1] = b1_s | b2_s;
  end

  // Next-state selection: reset forces zeros, otherwise take the new result.
  always_comb begin
    d_d    = {WIDTH{1'b0}};
    bout_d = 1'b0;
    if (rst) begin
      d_d    = {WIDTH{1'b0}};
      bout_d = 1'b0;
    end else begin
      d_d    = diff_s;
      bout_d = borrow_s[WIDTH];
    end
  end

  // Output registers: the only state in the block.
  always_ff @(posedge clk) begin
    d_q    <= d_d;
    bout_q <= bout_d;
  end

  assign d    = d_q;
  assign bout = bout_q;

endmodule : fullsubtractor_using_halfsubtractor

// File: tb/tb_fullsubtractor_using_halfsubtractor.sv
// -----------------------------------------------------------------------------
// Testbench for fullsubtractor_using_halfsubtractor.
// Two instances share one clock and one reset: a WIDTH=1 instance and a
// WIDTH=8 instance. Expected values come from a truth table (WIDTH=1) and
// from plain integer arithmetic (WIDTH=8).
// -----------------------------------------------------------------------------
module tb_fullsubtractor_using_halfsubtractor;

  logic       clk;
  logic       rst;

  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic [0:0] d1;
  logic       bout1;

  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic [7:0] d8;
  logic       bout8;

  int checks;
  int errors;

  // Truth table indexed by {a,b,bin}; each entry is {d,bout}.
  logic [1:0] tt [8];

  fullsubtractor_using_halfsubtractor #(.WIDTH(1)) u_dut1 (
    .d    (d1),
    .bout (bout1),
    .a    (a1),
    .b    (b1),
    .bin  (bin1),
    .clk  (clk),
    .rst  (rst)
  );

  fullsubtractor_using_halfsubtractor #(.WIDTH(8)) u_dut8 (
    .d    (d8),
    .bout (bout8),
    .a    (a8),
    .b    (b8),
    .bin  (bin8),
    .clk  (clk),
    .rst  (rst)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies rst for the coming edge, then samples 1 time unit after that edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  // 9-bit two's-complement reference: {bout,d} = a - b - bin.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return r[8:0];
  endfunction

  logic [1:0] exp1;
  logic [1:0] prev1;
  logic [8:0] exp8;
  logic [8:0] prev8;
  logic [2:0] v;

  initial begin
    checks = 0;
    errors = 0;
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    // Reset with non-zero inputs must clear both instances.
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
    a8 = 8'hA5; b8 = 8'h13; bin8 = 1'b1;
    step(1'b1);
    step(1'b1);
    check_val("rst_d1",    {63'd0, d1},    64'd0);
    check_val("rst_bout1", {63'd0, bout1}, 64'd0);
    check_val("rst_d8",    {56'd0, d8},    64'd0);
    check_val("rst_bout8", {63'd0, bout8}, 64'd0);

    // Sweep of the WIDTH=1 truth table, one vector per cycle.
    prev1 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, bin1} = v;
      #1;
      // Outputs must not follow the inputs before the edge.
      check_val("hold_w1", {62'd0, d1, bout1}, {62'd0, prev1});
      step(1'b0);
      exp1 = tt[i];
      check_val("sweep_w1", {62'd0, d1, bout1}, {62'd0, exp1});
      prev1 = exp1;
    end

    // Reset wins over a live 011 input; the next edge shows the 011 result.
    {a1, b1, bin1} = 3'b011;
    step(1'b1);
    check_val("rst_prio_w1", {62'd0, d1, bout1}, 64'd0);
    step(1'b0);
    check_val("post_rst_w1", {62'd0, d1, bout1}, 64'd1);

    // Boundary cases for WIDTH=8.
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
    step(1'b0);
    check_val("wrap_w8", {55'd0, bout8, d8}, {55'd0, 1'b1, 8'h00});
    a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b1;
    step(1'b0);
    check_val("eq_bin1_w8", {55'd0, bout8, d8}, {55'd0, 1'b1, 8'hFF});
    bin8 = 1'b0;
    step(1'b0);
    check_val("eq_bin0_w8", {55'd0, bout8, d8}, {55'd0, 1'b0, 8'h00});
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    step(1'b0);
    check_val("max_w8", {55'd0, bout8, d8}, {55'd0, 1'b0, 8'hFF});

    // Random back-to-back stream with one reset cycle in the middle.
    for (int i = 0; i < 1000; i++) begin
      logic r;
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      bin8 = 1'($urandom);
      v    = 3'($urandom);
      {a1, b1, bin1} = v;
      r = (i == 500);
      step(r);
      if (r) begin
        exp8 = 9'd0;
        exp1 = 2'b00;
      end else begin
        exp8 = ref8(a8, b8, bin8);
        exp1 = tt[v];
      end
      check_val("rand_w8", {55'd0, bout8, d8},  {55'd0, exp8});
      check_val("rand_w1", {62'd0, d1, bout1},  {62'd0, exp1});
    end

    // Final hold check: new inputs do not disturb the registered outputs.
    prev8 = {bout8, d8};
    exp8  = ref8(a8, b8, bin8);
    a8 = ~a8; b8 = b8 + 8'd1;
    #2;
    check_val("hold_w8", {55'd0, bout8, d8}, {55'd0, exp8});
    step(1'b0);
    check_val("last_w8", {55'd0, bout8, d8}, {55'd0, ref8(a8, b8, bin8)});
    if (prev8 !== exp8) begin
      // Already reported by rand_w8 on the last iteration; no extra count.
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fullsubtractor_using_halfsubtractor

// File: doc/fullsubtractor_using_halfsubtractor.md
FULLSUBTRACTOR_USING_HALFSUBTRACTOR -- requirements
Module: fullsubtractor_using_halfsubtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 The block SHALL have the following ports, listed here clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- d  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
REQ-003 The port declaration order SHALL be d, bout, a, b, bin, clk, rst, so that positional hookups of the first five ports keep their meaning.
REQ-004 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 The block SHALL contain a half_subtractor submodule:
- inputs x, y; outputs diff = x XOR y, brw = (NOT x) AND y.
REQ-006 Each bit i SHALL be a full-subtractor cell built from exactly two half_subtractor instances:
- HS1(a[i], b[i]) gives d1, b1.
- HS2(d1, borrow_i) gives d_i, b2.
- borrow_(i+1) = b1 OR b2.
REQ-007 The cells SHALL ripple LSB to MSB with borrow_0 = bin; bout SHALL be borrow_WIDTH.
REQ-008 Arithmetic rule, unsigned:
- d SHALL equal (a - b - bin) mod 2^WIDTH.
- bout SHALL be 1 iff a < b + bin.
REQ-009 For WIDTH = 1 the truth table for a, b, bin -> d, bout SHALL be:
- 000->00, 001->11, 010->11, 011->01
- 100->10, 101->00, 110->00, 111->11
REQ-010 The difference and borrow SHALL be computed combinationally from the current a, b, bin and captured into output registers on each rising clk edge.
REQ-011 Latency SHALL be exactly one clock cycle, with a new result every cycle (throughput 1/cycle) and no handshake.
REQ-012 Outputs SHALL change only at rising clk edges; they SHALL NOT change combinationally with inputs.
REQ-013 Boundary behaviour:
- a = 0, b = all-ones, bin = 1: d = 0, bout = 1 (full wrap-around).
- a = b, bin = 0: d = 0, bout = 0.
- a = b, bin = 1: d = all-ones, bout = 1.
REQ-014 Inputs containing X or Z SHALL NOT be required to produce defined outputs; no internal state other than the output registers SHALL exist.

Reset
REQ-015 When rst = 1 at a rising clk edge, d SHALL become 0 and bout SHALL become 0, regardless of a, b, bin.
REQ-016 Reset SHALL take priority over computation on the same edge.
REQ-017 On the first edge after rst is deasserted, the outputs SHALL reflect the inputs sampled at that edge.
REQ-018 Asserting rst mid-stream SHALL discard the pending result; no result SHALL be emitted for inputs sampled while rst = 1.
REQ-019 Before the first reset edge, output values SHALL be undefined; the bench SHALL apply reset first.

Verification
REQ-020 WIDTH=1, reset then sweep {a,b,bin} 000..111 one per cycle -> each output matches REQ-009 exactly one cycle after its input.
REQ-021 WIDTH=1, rst = 1 with {a,b,bin} = 011 -> d = 0, bout = 0 on that edge; after rst drops -> d = 0, bout = 1 next edge.
REQ-022 WIDTH=8, a = 0x00, b = 0xFF, bin = 1 -> d = 0x00, bout = 1 after one cycle.
REQ-023 WIDTH=8, a = 0x5A, b = 0x5A, bin = 1 -> d = 0xFF, bout = 1; same with bin = 0 -> d = 0x00, bout = 0.
REQ-024 WIDTH=8, 1000 random vectors, back-to-back -> {bout,d} equals a - b - bin as a 9-bit two's-complement result, delayed one cycle.
REQ-025 Reset asserted for one cycle mid-random-stream -> exactly one 0/0 output sample, then correct results resume with no extra delay.
